spi_shift_ctrl: RTL

SPI master shift engine between the transmit and receive byte FIFOs of the SPI block. It pops bytes from the TX FIFO, serialises them on MOSI with a programmable SCLK and mode, and captures MISO in parallel. Each received byte is pushed into the RX FIFO. Chip select stays asserted across back-to-back bytes while TX data is available.

---
 rtl/spi_shift_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl
// SPI master shift engine that sits between the TX and RX byte FIFOs.
// A byte is popped from the TX FIFO in LOAD and shifted out on MOSI while
// MISO is captured in parallel during SHIFT. The received byte is pushed in
// DONE. Chip select stays low across back-to-back bytes while TX data is
// available and the engine is enabled.
//
// Byte timing: LOAD (1) + SHIFT (17 half-periods of clk_div+1 cycles) +
// DONE (1). The 17th half-period is the closing interval after the last
// SCLK edge, so SCLK is back at its idle level before DONE.
module spi_shift_ctrl (
   input  logic       clk_i,
   input  logic       rstb_i,
   input  logic       en_i,
   input  logic       cpol_i,
   input  logic       cpha_i,
   input  logic       lsb_first_i,
   input  logic [7:0] clk_div_i,
   input  logic [7:0] tx_dout_i,
   input  logic       tx_empty_i,
   output logic       tx_read_o,
   output logic [7:0] rx_din_o,
   output logic       rx_write_o,
   input  logic       rx_full_i,
   output logic       sclk_o,
   output logic       mosi_o,
   input  logic       miso_i,
   output logic       csn_o,
   output logic       busy_o,
   output logic       rx_ovf_o,
   input  logic       ovf_clr_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;

   // SCLK generation: divider within a half-period, edge number, clock phase.
   // edge_cnt runs 0..15 for real SCLK edges; 16 marks the closing half-period.
   logic [7:0] div_cnt;
   logic [4:0] edge_cnt;
   logic       phase;

   // Per-byte configuration captured in LOAD.
   logic       cpol_q;
   logic       cpha_q;
   logic       lsb_q;
   logic [7:0] div_q;

   // Shift registers.
   logic [7:0] tx_sr;
   logic [7:0] rx_sr;
   logic       ovf_q;

   // Strobes derived from the divider and edge counter.
   logic       half_done;
   logic       edge_stb;
   logic       close_stb;
   logic       sample_stb;
   logic       shift_stb;
   logic       start_ok;
   logic       cpol_eff;

   // First bit presented on MOSI for a freshly loaded byte.
   function automatic logic first_bit(input logic [7:0] b, input logic lsb);
      first_bit = lsb ? b[0] : b[7];
   endfunction

   // Advance the transmit register so the next bit sits at the output position.
   function automatic logic [7:0] shift_out(input logic [7:0] b, input logic lsb);
      shift_out = lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
   endfunction

   // Insert a received bit so the byte assembles in transmit bit order.
   function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in,
                                           input logic lsb);
      shift_in = lsb ? {bit_in, b[7:1]} : {b[6:0], bit_in};
   endfunction

   // Decode divider terminal count and which SCLK edge (if any) fires this cycle.
   always_comb begin
      half_done  = (div_cnt == div_q);
      edge_stb   = (state == ST_SHIFT) && half_done && !edge_cnt[4];
      close_stb  = (state == ST_SHIFT) && half_done &&  edge_cnt[4];
      sample_stb = edge_stb && (edge_cnt[0] == cpha_q);
      // cpha=0: new data after each trailing edge except the last one.
      // cpha=1: new data on each leading edge except edge 0, because the
      // first bit is already on MOSI from LOAD.
      if (cpha_q) begin
         shift_stb = edge_stb && !edge_cnt[0] && (edge_cnt[3:0] != 4'd0);
      end else begin
         shift_stb = edge_stb &&  edge_cnt[0] && (edge_cnt[3:0] != 4'd15);
      end
      start_ok   = en_i && !tx_empty_i;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and FIFO handshake / chip-select outputs.
   always_comb begin
      state_nxt  = state;
      tx_read_o  = 1'b0;
      rx_write_o = 1'b0;
      csn_o      = 1'b0;
      busy_o     = 1'b1;
      unique case (state)
         ST_IDLE: begin
            csn_o  = 1'b1;
            busy_o = 1'b0;
            if (start_ok) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            tx_read_o = !tx_empty_i;
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (close_stb) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            rx_write_o = !rx_full_i;
            state_nxt  = start_ok ? ST_LOAD : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Half-period divider, edge counter and SCLK phase; idle outside SHIFT.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         div_cnt  <= 8'd0;
         edge_cnt <= 5'd0;
         phase    <= 1'b0;
      end else if (state == ST_SHIFT) begin
         if (half_done) begin
            div_cnt <= 8'd0;
            if (!edge_cnt[4]) begin
               phase    <= ~phase;
               edge_cnt <= edge_cnt + 5'd1;
            end
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end else begin
         div_cnt  <= 8'd0;
         edge_cnt <= 5'd0;
         phase    <= 1'b0;
      end
   end

   // Capture mode and divider for the byte; they are frozen until the next LOAD.
   always_ff @(posedge clk_i) begin
      if (state == ST_LOAD) begin
         cpol_q <= cpol_i;
         cpha_q <= cpha_i;
         lsb_q  <= lsb_first_i;
         div_q  <= clk_div_i;
      end
   end

   // Transmit shift register: loaded from the FIFO head, advanced on shift edges.
   always_ff @(posedge clk_i) begin
      if (state == ST_LOAD) begin
         tx_sr <= tx_dout_i;
      end else if (shift_stb) begin
         tx_sr <= shift_out(tx_sr, lsb_q);
      end
   end

   // Receive shift register; reset clears any partial byte from rx_din_o.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         rx_sr <= 8'h00;
      end else if (sample_stb) begin
         rx_sr <= shift_in(rx_sr, miso_i, lsb_q);
      end
   end

   // Sticky overflow flag; a clear request wins over a same-cycle drop.
   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         ovf_q <= 1'b0;
      end else if (ovf_clr_i) begin
         ovf_q <= 1'b0;
      end else if ((state == ST_DONE) && rx_full_i) begin
         ovf_q <= 1'b1;
      end
   end

   // Serial outputs: SCLK idles at the live cpol until the latched copy takes over.
   always_comb begin
      cpol_eff = ((state == ST_IDLE) || (state == ST_LOAD)) ? cpol_i : cpol_q;
      sclk_o   = cpol_eff ^ phase;
      if (state == ST_IDLE) begin
         mosi_o = 1'b0;
      end else if (state == ST_LOAD) begin
         mosi_o = first_bit(tx_dout_i, lsb_first_i);
      end else begin
         mosi_o = first_bit(tx_sr, lsb_q);
      end
      rx_din_o = rx_sr;
      rx_ovf_o = ovf_q;
   end

endmodule
